fd_reg: RTL and testbench

- F/D pipeline register of the 5-stage MIPS core with exception support.
- Captures the fetch-stage PC and instruction at the program-counter output, and performs the fetch-address exception check (AdEL).
- Records the branch-delay-slot flag and hands a clean, annotated instruction packet to the decode stage.
- Honours stall (hold), exception/interrupt request (flush to handler PC) and reset. Also keeps a retired-to-decode fetch counter for debug.

---
 rtl/fd_reg.sv | 56 +++++
 tb/tb_fd_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fd_reg.sv
// F/D pipeline register: latches fetch PC/instruction, flags
// fetch address errors (AdEL), delay-slot bit and a debug fetch count.
module fd_reg #(
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_END     = 32'h0000_6FFC,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        en,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode,
  output logic        d_bd,
  output logic        d_valid,
  output logic [31:0] fetch_cnt
);

  logic adel;

  assign adel = (f_pc[1:0] != 2'b00)
              | (f_pc < IM_BASE)
              | (f_pc > IM_END);

  // Flush parks d_pc on the handler so the visible PC stays there
  // while the bubble drains; fetch_cnt only counts real packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_pc      <= IM_BASE;
      d_instr   <= 32'd0;
      d_exccode <= 5'd0;
      d_bd      <= 1'b0;
      d_valid   <= 1'b0;
      fetch_cnt <= 32'd0;
    end else if (req) begin
      d_pc      <= HANDLER_PC;
      d_instr   <= 32'd0;
      d_exccode <= 5'd0;
      d_bd      <= 1'b0;
      d_valid   <= 1'b0;
    end else if (en) begin
      d_pc      <= f_pc;
      d_instr   <= adel ? 32'd0 : f_instr;
      d_exccode <= adel ? EXC_ADEL : 5'd0;
      d_bd      <= f_bd;
      d_valid   <= 1'b1;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fd_reg.sv
// Self-checking bench for fd_reg: directed vector table,
// hand corner sequences and randomized run against a model.
module tb_fd_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        en = 1'b0;
  logic [31:0] f_pc = 32'h3000;
  logic [31:0] f_instr = 32'd0;
  logic        f_bd = 1'b0;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [4:0]  d_exccode;
  logic        d_bd;
  logic        d_valid;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail = 0;

  fd_reg dut (
    .clk(clk), .reset(reset), .req(req), .en(en),
    .f_pc(f_pc), .f_instr(f_instr), .f_bd(f_bd),
    .d_pc(d_pc), .d_instr(d_instr),
    .d_exccode(d_exccode), .d_bd(d_bd),
    .d_valid(d_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rq;
    logic        e;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        bd;
    logic [31:0] x_pc;
    logic [31:0] x_ins;
    logic [4:0]  x_exc;
    logic        x_bd;
    logic        x_val;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t vt[17];

  // reference model state
  logic [31:0] m_pc, m_ins, m_cnt;
  logic [4:0]  m_exc;
  logic        m_bd, m_val;

  function automatic bit legal(input logic [31:0] pc);
    longint unsigned p = pc;
    return (p % 4 == 0) && p >= 64'h3000 && p <= 64'h6FFC;
  endfunction

  task automatic model(input logic r, input logic q,
                       input logic e, input logic [31:0] pc,
                       input logic [31:0] ins, input logic bd);
    if (r) begin
      m_pc = 32'h3000; m_ins = 0; m_exc = 0;
      m_bd = 0; m_val = 0; m_cnt = 0;
    end else if (q) begin
      m_pc = 32'h4180; m_ins = 0; m_exc = 0;
      m_bd = 0; m_val = 0;
    end else if (e) begin
      m_pc = pc;
      m_bd = bd;
      m_val = 1;
      m_cnt = 32'((64'(m_cnt) + 1) % 64'h1_0000_0000);
      if (legal(pc)) begin
        m_ins = ins; m_exc = 0;
      end else begin
        m_ins = 0; m_exc = 5'd4;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] xp,
                         input logic [31:0] xi, input logic [4:0] xe,
                         input logic xb, input logic xv,
                         input logic [31:0] xc);
    chk({tag, " d_pc"}, d_pc, xp);
    chk({tag, " d_instr"}, d_instr, xi);
    chk({tag, " d_exccode"}, 32'(d_exccode), 32'(xe));
    chk({tag, " d_bd"}, 32'(d_bd), 32'(xb));
    chk({tag, " d_valid"}, 32'(d_valid), 32'(xv));
    chk({tag, " fetch_cnt"}, fetch_cnt, xc);
  endtask

  task automatic drive(input logic r, input logic q,
                       input logic e, input logic [31:0] pc,
                       input logic [31:0] ins, input logic bd);
    reset = r; req = q; en = e;
    f_pc = pc; f_instr = ins; f_bd = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic r, input logic q, input logic e,
    input logic [31:0] pc, input logic [31:0] ins, input logic bd,
    input logic [31:0] xp, input logic [31:0] xi,
    input logic [4:0] xe, input logic xb, input logic xv,
    input logic [31:0] xc);
    vec_t v;
    v.rst = r; v.rq = q; v.e = e; v.pc = pc; v.ins = ins;
    v.bd = bd; v.x_pc = xp; v.x_ins = xi; v.x_exc = xe;
    v.x_bd = xb; v.x_val = xv; v.x_cnt = xc;
    return v;
  endfunction

  initial begin
    vt[0]  = mk(1,0,0,'h3000,'h0,0,       'h3000,0,0,0,0,0);
    vt[1]  = mk(0,0,1,'h3000,'h3C011234,0,
                'h3000,'h3C011234,0,0,1,1);
    vt[2]  = mk(0,0,0,'h3004,'h11111111,1,
                'h3000,'h3C011234,0,0,1,1);
    vt[3]  = mk(0,0,0,'h3008,'h22222222,0,
                'h3000,'h3C011234,0,0,1,1);
    vt[4]  = mk(0,0,0,'h300C,'h33333333,1,
                'h3000,'h3C011234,0,0,1,1);
    vt[5]  = mk(0,0,1,'h3010,'h44444444,0,
                'h3010,'h44444444,0,0,1,2);
    vt[6]  = mk(0,0,1,'h3002,'h55555555,0,'h3002,0,4,0,1,3);
    vt[7]  = mk(0,0,1,'h7000,'h66666666,0,'h7000,0,4,0,1,4);
    vt[8]  = mk(0,0,1,'h2FFC,'h77777777,0,'h2FFC,0,4,0,1,5);
    vt[9]  = mk(0,0,1,'h6FFC,'h88888888,0,
                'h6FFC,'h88888888,0,0,1,6);
    vt[10] = mk(0,1,0,'h3010,'h12345678,0,'h4180,0,0,0,0,6);
    vt[11] = mk(0,0,1,'h3008,'h99999999,1,
                'h3008,'h99999999,0,1,1,7);
    vt[12] = mk(0,0,1,'h300C,'hAAAAAAAA,0,
                'h300C,'hAAAAAAAA,0,0,1,8);
    vt[13] = mk(0,1,1,'h7000,'hBBBBBBBB,1,'h4180,0,0,0,0,8);
    vt[14] = mk(0,0,1,'h7000,'hBBBBBBBB,1,'h7000,0,4,1,1,9);
    vt[15] = mk(1,0,0,'h3020,'hCCCCCCCC,1,'h3000,0,0,0,0,0);
    vt[16] = mk(0,0,1,'h6FFE,'hDDDDDDDD,0,'h6FFE,0,4,0,1,1);

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].rq, vt[i].e,
            vt[i].pc, vt[i].ins, vt[i].bd);
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].x_pc, vt[i].x_ins,
              vt[i].x_exc, vt[i].x_bd, vt[i].x_val, vt[i].x_cnt);
    end

    // counter wrap: preload all-ones, then one advance
    drive(0, 0, 0, 'h3000, 'h01010101, 0);
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    drive(0, 0, 1, 'h3004, 'h02020202, 0);
    tick();
    chk("wrap fetch_cnt", fetch_cnt, 32'h0);
    chk("wrap d_pc", d_pc, 32'h3004);

    // stall then an advance must count exactly once
    drive(0, 0, 0, 'h3008, 'h03030303, 0);
    tick();
    chk("stall fetch_cnt", fetch_cnt, 32'h0);
    drive(0, 0, 1, 'h3008, 'h03030303, 0);
    tick();
    chk("post-wrap fetch_cnt", fetch_cnt, 32'h1);

    // reset dominates req and en together
    drive(1, 1, 1, 'h3010, 'h04040404, 1);
    tick();
    chk_all("rst+req+en", 'h3000, 0, 0, 0, 0, 0);

    // randomized run against the model
    model(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      logic r, q, e, bd;
      logic [31:0] pc, ins;
      int sel;
      r = ($urandom_range(0, 49) == 0);
      q = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 9) < 7);
      bd = 1'($urandom);
      ins = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: pc = 32'h3000;
        1: pc = 32'h6FFC;
        2: pc = 32'h2FFC;
        3: pc = 32'h7000;
        4: pc = $urandom;
        default: begin
          pc = 32'h2FF0 + 32'($urandom_range(0, 'h4020));
          if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
        end
      endcase
      drive(r, q, e, pc, ins, bd);
      tick();
      model(r, q, e, pc, ins, bd);
      if (d_pc !== m_pc || d_instr !== m_ins ||
          d_exccode !== m_exc || d_bd !== m_bd ||
          d_valid !== m_val || fetch_cnt !== m_cnt) begin
        chk_all($sformatf("rnd%0d", c), m_pc, m_ins, m_exc,
                m_bd, m_val, m_cnt);
      end else begin
        n_checks++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
